// File: rtl/lift_dispatch_fsm_pkg.sv
// Shared types for the lift dispatcher: state encoding, floor/lamp widths and
// helpers that look for pending requests on either side of the car.
package lift_dispatch_fsm_pkg;

    localparam int N_FLOOR = 4;
    localparam int FLOOR_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OPEN = 2'd2
    } state_t;

    typedef logic [N_FLOOR-1:0] lamp_t;
    typedef logic [FLOOR_W-1:0] floor_t;

    function automatic logic req_above(input lamp_t lamp, input floor_t f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOOR; i++) begin
            if (lamp[i] && (i > int'(f))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic req_below(input lamp_t lamp, input floor_t f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOOR; i++) begin
            if (lamp[i] && (i < int'(f))) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lift_dispatch_fsm_if.sv
// Call buttons, timer handshakes and status outputs of the lift dispatcher.
// master drives the calls and timer-done levels, slave is the dispatcher.
interface lift_dispatch_fsm_if;
    import lift_dispatch_fsm_pkg::*;

    lamp_t  call_req;
    logic   endRun;
    logic   endOpen;
    logic   StRun;
    logic   StOpen;
    floor_t floor;
    logic   dir_up;
    lamp_t  req_lamp;

    modport master (
        output call_req, endRun, endOpen,
        input  StRun, StOpen, floor, dir_up, req_lamp
    );

    modport slave (
        input  call_req, endRun, endOpen,
        output StRun, StOpen, floor, dir_up, req_lamp
    );

endinterface

// File: rtl/lift_dispatch_fsm_rise_det.sv
// Rising-edge detector: one-cycle pulse when d goes high relative to its
// registered copy, so a level held for many cycles yields a single event.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/lift_dispatch_fsm.sv
// Single-car dispatcher: latches floor calls, steers the run timer one floor
// at a time and opens the door at requested floors, serving the current direction first.
module lift_dispatch_fsm #(
    parameter int N_FLOOR    = 4,
    parameter int HOME_FLOOR = 0
) (
    input  logic                 CP,
    input  logic                 rst,
    lift_dispatch_fsm_if.slave   bus
);
    import lift_dispatch_fsm_pkg::*;

    logic   run_ev, open_ev;
    state_t state, state_n;
    floor_t floor_q, floor_n, nxt;
    logic   dir_q, dir_n, at_end;
    lamp_t  lamp_q, lamp_n, clr, call_mask;

    rise_det u_run_det (
        .clk   (CP),
        .rst   (rst),
        .d     (bus.endRun),
        .pulse (run_ev)
    );

    rise_det u_open_det (
        .clk   (CP),
        .rst   (rst),
        .d     (bus.endOpen),
        .pulse (open_ev)
    );

    always_ff @(posedge CP) begin
        if (rst) begin
            state   <= IDLE;
            floor_q <= floor_t'(HOME_FLOOR);
            dir_q   <= 1'b1;
            lamp_q  <= '0;
        end else begin
            state   <= state_n;
            floor_q <= floor_n;
            dir_q   <= dir_n;
            lamp_q  <= lamp_n;
        end
    end

    always_comb begin
        state_n = state;
        floor_n = floor_q;
        dir_n   = dir_q;
        clr     = '0;
        nxt     = dir_q ? floor_q + floor_t'(1) : floor_q - floor_t'(1);
        at_end  = dir_q ? (floor_q == floor_t'(N_FLOOR - 1)) : (floor_q == '0);

        unique case (state)
            IDLE: begin
                if (lamp_q[floor_q]) begin
                    state_n        = OPEN;
                    clr[floor_q]   = 1'b1;
                end else if (|lamp_q) begin
                    // keep heading the same way while anything is pending on that side
                    if (dir_q ? !req_above(lamp_q, floor_q) : !req_below(lamp_q, floor_q))
                        dir_n = ~dir_q;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (run_ev) begin
                    if (at_end) begin
                        state_n = IDLE;
                    end else begin
                        floor_n = nxt;
                        if (lamp_q[nxt]) begin
                            state_n  = OPEN;
                            clr[nxt] = 1'b1;
                        end
                    end
                end
            end
            OPEN: begin
                if (open_ev) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // a press at the floor whose door is already open is absorbed
        call_mask = bus.call_req;
        if (state == OPEN) call_mask[floor_q] = 1'b0;
        lamp_n = (lamp_q | call_mask) & ~clr;
    end

    assign bus.StRun    = (state == RUN);
    assign bus.StOpen   = (state == OPEN);
    assign bus.floor    = floor_q;
    assign bus.dir_up   = dir_q;
    assign bus.req_lamp = lamp_q;

endmodule

// File: tb/tb_lift_dispatch_fsm.sv
// Bench for lift_dispatch_fsm: directed scenarios then random calls/timer levels,
// every cycle compared against a rule-level model of the dispatcher.
module tb_lift_dispatch_fsm;

    logic CP = 1'b0;
    logic rst;
    always #5 CP = ~CP;

    lift_dispatch_fsm_if bus ();

    lift_dispatch_fsm #(.N_FLOOR(4), .HOME_FLOOR(0)) dut (
        .CP  (CP),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    // model: mode 0 = parked, 1 = travelling, 2 = door open
    int     m_mode, m_floor;
    bit     m_up, m_er_q, m_eo_q;
    bit [3:0] m_lamp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit [3:0] call, input bit er, input bit eo, input bit r);
        bit run_edge, open_edge;
        int prev_mode, prev_floor, clear_at, target, above, below;
        bit [3:0] nl;
        if (r) begin
            m_mode = 0; m_floor = 0; m_up = 1; m_lamp = 0; m_er_q = 0; m_eo_q = 0;
            return;
        end
        run_edge  = er && !m_er_q;
        open_edge = eo && !m_eo_q;
        m_er_q = er;
        m_eo_q = eo;
        prev_mode  = m_mode;
        prev_floor = m_floor;
        clear_at   = -1;
        above = 0;
        below = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_lamp[i] && i > m_floor) above++;
            if (m_lamp[i] && i < m_floor) below++;
        end
        if (m_mode == 0) begin
            if (m_lamp[m_floor]) begin
                m_mode = 2;
                clear_at = m_floor;
            end else if (m_lamp != 0) begin
                if (m_up ? (above == 0) : (below == 0)) m_up = !m_up;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (run_edge) begin
                target = m_floor + (m_up ? 1 : -1);
                if (target < 0 || target > 3) begin
                    m_mode = 0;
                end else begin
                    m_floor = target;
                    if (m_lamp[target]) begin
                        m_mode = 2;
                        clear_at = target;
                    end
                end
            end
        end else begin
            if (open_edge) m_mode = 0;
        end
        nl = m_lamp;
        for (int i = 0; i < 4; i++) begin
            if (call[i] && !(prev_mode == 2 && i == prev_floor)) nl[i] = 1'b1;
            if (i == clear_at) nl[i] = 1'b0;
        end
        m_lamp = nl;
    endtask

    task automatic compare_all();
        chk("st_run",   bus.StRun,    (m_mode == 1));
        chk("st_open",  bus.StOpen,   (m_mode == 2));
        chk("floor",    bus.floor,    m_floor);
        chk("dir_up",   bus.dir_up,   m_up);
        chk("req_lamp", bus.req_lamp, m_lamp);
    endtask

    task automatic cycle(input bit [3:0] call, input bit er, input bit eo, input bit r);
        bus.call_req = call;
        bus.endRun   = er;
        bus.endOpen  = eo;
        rst          = r;
        @(posedge CP);
        model_step(call, er, eo, r);
        #1;
        compare_all();
    endtask

    task automatic idle1();     cycle(4'b0000, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_reset();  cycle(4'b0000, 1'b0, 1'b0, 1'b1); endtask
    task automatic call(input bit [3:0] c); cycle(c, 1'b0, 1'b0, 1'b0); endtask
    task automatic run_step();  cycle(4'b0000, 1'b1, 1'b0, 1'b0); idle1(); endtask
    task automatic door_done(); cycle(4'b0000, 1'b0, 1'b1, 1'b0); endtask

    initial begin
        rst = 1'b1;
        bus.call_req = '0;
        bus.endRun   = 1'b0;
        bus.endOpen  = 1'b0;

        // reset state
        do_reset();
        chk("rst_floor", bus.floor, 0);
        chk("rst_dir", bus.dir_up, 1);
        chk("rst_lamp", bus.req_lamp, 0);
        chk("rst_run", bus.StRun, 0);
        chk("rst_open", bus.StOpen, 0);

        // top-floor call from home
        call(4'b1000);
        idle1();
        chk("s1_run", bus.StRun, 1);
        chk("s1_dir", bus.dir_up, 1);
        run_step(); run_step(); run_step();
        chk("s1_floor", bus.floor, 3);
        chk("s1_open", bus.StOpen, 1);
        door_done();
        chk("s1_idle", {bus.StRun, bus.StOpen}, 0);
        chk("s1_lamp", bus.req_lamp, 0);

        // call at the current floor opens without moving; re-press while open is absorbed
        do_reset();
        call(4'b0001);
        chk("s2_lamp_set", bus.req_lamp, 4'b0001);
        idle1();
        chk("s2_open", bus.StOpen, 1);
        chk("s2_norun", bus.StRun, 0);
        chk("s2_lamp_clr", bus.req_lamp, 0);
        call(4'b0001);
        chk("s2_absorbed", bus.req_lamp, 0);
        door_done();

        // intermediate stop on the way up
        do_reset();
        call(4'b1000);
        idle1();
        run_step();
        chk("s3_floor1", bus.floor, 1);
        call(4'b0100);
        idle1();
        run_step();
        chk("s3_floor2", bus.floor, 2);
        chk("s3_open2", bus.StOpen, 1);
        door_done();
        idle1();
        chk("s3_resume", bus.StRun, 1);
        chk("s3_dir", bus.dir_up, 1);
        run_step();
        chk("s3_floor3", bus.floor, 3);
        chk("s3_open3", bus.StOpen, 1);
        door_done();

        // up-first service then reversal
        do_reset();
        call(4'b0100);
        idle1();
        run_step(); run_step();
        chk("s4_at2", bus.floor, 2);
        call(4'b1001);
        door_done();
        idle1();
        chk("s4_up", bus.dir_up, 1);
        run_step();
        chk("s4_at3", bus.floor, 3);
        chk("s4_open3", bus.StOpen, 1);
        door_done();
        idle1();
        chk("s4_down", bus.dir_up, 0);
        chk("s4_run", bus.StRun, 1);
        run_step(); run_step(); run_step();
        chk("s4_at0", bus.floor, 0);
        chk("s4_open0", bus.StOpen, 1);
        chk("s4_lamp", bus.req_lamp, 0);
        door_done();

        // long endRun level counts once
        do_reset();
        call(4'b1000);
        idle1();
        for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle1();
        chk("s5_once", bus.floor, 1);
        chk("s5_run", bus.StRun, 1);

        // reset while travelling from 1 towards 2
        do_reset();
        chk("s6_floor", bus.floor, 0);
        chk("s6_run", bus.StRun, 0);
        chk("s6_lamp", bus.req_lamp, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] c;
            c = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cycle(c, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
